// File: rtl/seg_scan_driver.sv
// 8-digit time-multiplexed seven-segment scan driver with tear-free frame-boundary updates.
// Optional build macro LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module seg_scan_driver #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  en_mask,
  input  logic [7:0]  dp_mask,
  input  logic        load,
  output logic [7:0]  AN,
  output logic [7:0]  Ca,
  output logic        frame_start
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_DRIVE} slot_state_t;
  localparam slot_state_t SLOT0_STATE = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg;
  slot_state_t   state_reg, state_next;
  logic [31:0]   shadow_data_reg, pend_data_reg;
  logic [7:0]    shadow_en_reg, shadow_dp_reg, pend_en_reg, pend_dp_reg;
  logic          pend_valid_reg;
  logic          seen_boundary_reg;
  logic [7:0]    an_reg, an_next, ca_reg, ca_next;
  logic          frame_start_reg;
  logic          wrap, boundary;
  logic [3:0]    cur_nibble;
  logic [7:0]    show_mask;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  assign wrap       = (cnt_reg == LAST_CNT);
  assign boundary   = wrap && (idx_reg == 3'd7);
  assign cur_nibble = shadow_data_reg[{idx_reg, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_zero;

  // A zero digit is hidden only while nothing non-zero and enabled sits to its left.
  always_comb begin
    show_mask   = shadow_en_reg;
    higher_zero = 1'b1;
    for (int k = 1; k < 8; k++) begin
      higher_zero = 1'b1;
      for (int j = k + 1; j < 8; j++) begin
        if (shadow_en_reg[j] && (shadow_data_reg[4*j +: 4] != 4'h0)) higher_zero = 1'b0;
      end
      if ((shadow_data_reg[4*k +: 4] == 4'h0) && higher_zero) show_mask[k] = 1'b0;
    end
  end
`else
  for (genvar gi = 0; gi < 8; gi++) begin : g_show
    assign show_mask[gi] = shadow_en_reg[gi];
  end
`endif

  always_comb begin
    cnt_next   = wrap ? '0 : cnt_reg + CW'(1);
    state_next = state_reg;
    an_next    = 8'hFF;
    ca_next    = 8'hFF;
    if (wrap) begin
      state_next = SLOT0_STATE;
    end else if (cnt_next == BLANK_CNT) begin
      state_next = ST_DRIVE;
    end
    if (state_reg == ST_DRIVE && show_mask[idx_reg]) begin
      an_next = ~(8'b1 << idx_reg);
      ca_next = {~shadow_dp_reg[idx_reg], ~hex_to_seg(cur_nibble)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg           <= '0;
      idx_reg           <= '0;
      state_reg         <= SLOT0_STATE;
      shadow_data_reg   <= '0;
      shadow_en_reg     <= '0;
      shadow_dp_reg     <= '0;
      pend_data_reg     <= '0;
      pend_en_reg       <= '0;
      pend_dp_reg       <= '0;
      pend_valid_reg    <= 1'b0;
      seen_boundary_reg <= 1'b0;
      an_reg            <= 8'hFF;
      ca_reg            <= 8'hFF;
      frame_start_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
      an_reg    <= an_next;
      ca_reg    <= ca_next;
      if (wrap) idx_reg <= idx_reg + 3'd1;
      if (boundary) seen_boundary_reg <= 1'b1;
      // Pulse lines up with the first output cycle of slot 0, skipping the post-reset frame.
      frame_start_reg <= (cnt_reg == '0) && (idx_reg == 3'd0) && seen_boundary_reg;

      if (load) begin
        pend_data_reg <= data;
        pend_en_reg   <= en_mask;
        pend_dp_reg   <= dp_mask;
      end
      if (boundary && load) begin
        shadow_data_reg <= data;
        shadow_en_reg   <= en_mask;
        shadow_dp_reg   <= dp_mask;
        pend_valid_reg  <= 1'b0;
      end else if (boundary && pend_valid_reg) begin
        shadow_data_reg <= pend_data_reg;
        shadow_en_reg   <= pend_en_reg;
        shadow_dp_reg   <= pend_dp_reg;
        pend_valid_reg  <= 1'b0;
      end else if (load) begin
        pend_valid_reg  <= 1'b1;
      end
    end
  end

  assign AN          = an_reg;
  assign Ca          = ca_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random loads,
// compared every cycle against a frame/slot arithmetic reference model.
module tb_seg_scan_driver;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME = 8 * TD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  en_mask = '0;
  logic [7:0]  dp_mask = '0;
  logic        load = 1'b0;
  logic [7:0]  AN;
  logic [7:0]  Ca;
  logic        frame_start;

  seg_scan_driver #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .data(data), .en_mask(en_mask), .dp_mask(dp_mask),
    .load(load), .AN(AN), .Ca(Ca), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mn = clock edges since reset; shadow/pending as plain variables.
  int          mn = 0;
  logic [31:0] m_sh_d = '0, m_pe_d = '0;
  logic [7:0]  m_sh_en = '0, m_sh_dp = '0, m_pe_en = '0, m_pe_dp = '0;
  bit          m_pv = 1'b0;
  logic [7:0]  exp_an = 8'hFF, exp_ca = 8'hFF;
  logic        exp_fs = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, mn);
  endtask

  function automatic bit digit_shown(input int d);
    logic [31:0] dv;
    dv = m_sh_d;
    if (!m_sh_en[d]) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && dv[4*d +: 4] == 4'h0) begin
      for (int j = d + 1; j < 8; j++)
        if (m_sh_en[j] && dv[4*j +: 4] != 4'h0) return 1'b1;
      return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  task automatic model_edge();
    int p, d, c;
    logic [31:0] dv;
    if (rst) begin
      mn = 0; m_pv = 1'b0;
      m_sh_d = '0; m_sh_en = '0; m_sh_dp = '0;
      m_pe_d = '0; m_pe_en = '0; m_pe_dp = '0;
      exp_an = 8'hFF; exp_ca = 8'hFF; exp_fs = 1'b0;
      return;
    end
    p = mn;
    mn++;
    c = p % TD;
    d = (p / TD) % 8;
    dv = m_sh_d;
    exp_an = 8'hFF;
    exp_ca = 8'hFF;
    if (c >= BC && digit_shown(d)) begin
      exp_an = 8'hFF;
      exp_an[d] = 1'b0;
      exp_ca = {~m_sh_dp[d], ~seg_tab[dv[4*d +: 4]]};
    end
    exp_fs = (p % FRAME == 0) && (p >= FRAME);
    if (load) begin
      if (mn % FRAME == 0) begin
        m_sh_d = data; m_sh_en = en_mask; m_sh_dp = dp_mask; m_pv = 1'b0;
      end else begin
        m_pe_d = data; m_pe_en = en_mask; m_pe_dp = dp_mask; m_pv = 1'b1;
      end
    end else if (mn % FRAME == 0 && m_pv) begin
      m_sh_d = m_pe_d; m_sh_en = m_pe_en; m_sh_dp = m_pe_dp; m_pv = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("AN", {24'h0, AN}, {24'h0, exp_an});
    check_val("Ca", {24'h0, Ca}, {24'h0, exp_ca});
    check_val("frame_start", {31'h0, frame_start}, {31'h0, exp_fs});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (mn % FRAME) != phase; i++) cycle();
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] dp);
    data = d; en_mask = e; dp_mask = dp; load = 1'b1;
    cycle();
    load = 1'b0;
    data = $urandom; en_mask = 8'($urandom); dp_mask = 8'($urandom);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2);
    run(FRAME + 8);

    // basic scan of all digits
    do_load(32'h89ABCDEF, 8'hFF, 8'h00);
    run(2 * FRAME + 10);

    // enable and decimal-point masks
    do_load(32'h00000321, 8'h05, 8'h04);
    run(2 * FRAME);

    // two loads mid-frame, last one wins at the next boundary
    run_to(20);
    do_load(32'h11111111, 8'hFF, 8'h00);
    cycle();
    do_load(32'h22222222, 8'hFF, 8'h00);
    run(2 * FRAME);

    // stale pending must be discarded by a load on the boundary cycle
    run_to(30);
    do_load(32'h44444444, 8'hFF, 8'hFF);
    run_to(FRAME - 1);
    do_load(32'h00000705, 8'hFF, 8'h10);
    run(2 * FRAME + 5);

    // reset during slot 3 drive phase
    run_to(29);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(FRAME + 10);
    do_load(32'hFEDCBA98, 8'hA5, 8'h5A);
    run(2 * FRAME);

    // randomized loads, occasional reset
    for (int r = 0; r < 16; r++) begin
      run($urandom_range(0, 90));
      if (r == 9) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      do_load($urandom, 8'($urandom), 8'($urandom));
    end
    run(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed 8-digit seven-segment scan driver for the Nexys 4 DDR display. Sits directly downstream of the nibble/hex conversion stage. It accepts eight 4-bit hex values plus per-digit enable and decimal-point masks, and drives the shared active-low cathode bus (Ca) and the anodes (AN) one digit at a time. It replaces the single fixed-anode display path with full 8-digit output.

Parameters:
TICK_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz; 8 ms frame); minimum 4
BLANK_CYCLES, 200, cycles at the start of each slot with all anodes off (anti-ghosting); must be < TICK_DIV

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous reset, active-high
data  input  32  hex digits; data[4k+3:4k] = digit k, digit 0 rightmost
en_mask  input  8  en_mask[k]=1 displays digit k; 0 keeps its anode off for the whole slot
dp_mask  input  8  dp_mask[k]=1 lights the decimal point of digit k
load  input  1  one-cycle strobe; captures data/en_mask/dp_mask into the pending register
AN  output  8  anodes, active-low, AN[k] = digit k
Ca  output  8  cathodes, active-low; Ca[0..6] = segments a..g, Ca[7] = dp
frame_start  output  1  one-cycle pulse when slot 0 of a new frame begins

Behaviour:
- Reset (rst=1 at a clk edge):
  - slot counter = 0, digit index = 0.
  - Shadow and pending registers cleared (data=0, en_mask=0, dp_mask=0); pending_valid = 0.
  - AN = 8'hFF, Ca = 8'hFF, frame_start = 0.
  - Reset mid-slot or mid-frame aborts immediately; no partial digit is emitted afterwards.
- Slot counter: counts 0..TICK_DIV-1 and wraps to 0. Digit index increments 0..7 at each wrap, 7 -> 0.
- Two-state FSM per slot:
  - BLANK: counter < BLANK_CYCLES. AN = FF, Ca = FF.
  - DRIVE: counter >= BLANK_CYCLES. AN = ~(1<<index) if shadow en_mask[index], else FF. Ca = {~dp, ~seg(nibble)} when enabled, else FF.
  - BLANK -> DRIVE when counter reaches BLANK_CYCLES. DRIVE -> BLANK on counter wrap.
- AN and Ca are registered: they change exactly one clk after the internal counter/index/shadow that produce them. No combinational path from any input to any output.
- Hex decode (segments g..a, 1 = lit): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Ca carries the inverse.
- Load handshake (tear-free update):
  - load=1 writes the inputs to pending and sets pending_valid. The last load before a frame boundary wins.
  - At a frame boundary (counter wrap with index 7 -> 0) with pending_valid=1: shadow <= pending, pending_valid <= 0.
  - load in the same cycle as the boundary: the load's inputs go straight to shadow and pending_valid stays 0.
  - Inputs are ignored when load=0; the shadow changes only at frame boundaries.
- frame_start: high for exactly one cycle, registered and aligned with the first BLANK cycle of slot 0. It is not asserted on the first frame after reset; the first pulse comes after 8*TICK_DIV cycles.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: an enabled digit whose nibble is 0 is blanked (AN bit held 1) when every higher-index digit is either 0 or disabled. Digit 0 is always shown if enabled. Suppression uses shadow values only.
- Undefined: every enabled digit is shown, zeros included. No suppression logic is synthesized.

Test Plan (TICK_DIV=8, BLANK_CYCLES=2):
- Reset: hold rst 3 cycles -> AN=FF, Ca=FF, frame_start=0 throughout and for 2 cycles after release; the first frame is fully blank.
- Basic scan: load data=32'h89ABCDEF, en_mask=FF, dp_mask=00, then wait for a frame boundary -> for each slot, 2 cycles AN=FF, then 6 cycles with AN=FE and Ca=8'h8E (digit 0 'F'), ..., AN=7F and Ca=8'h80 (digit 7 '8'); pattern repeats every 64 cycles.
- Masks: en_mask=8'h05, dp_mask=8'h04, data=32'h00000321 -> only AN=FE (Ca=F9, '1') and AN=FB (Ca=30, '3' with dp) are driven; the other slots stay FF.
- Tear-free load: load 32'h11111111 mid-frame, then 32'h22222222 two cycles later -> the current frame is unchanged; the next frame shows all '2' (Ca=A4); frame_start pulses once per 64 cycles.
- Boundary collision: assert load in the exact boundary cycle -> the new data appears in slot 0 of the frame just starting, and pending_valid=0 afterwards.
- Reset mid-DRIVE: rst at slot 3, cycle 5 -> AN=FF and Ca=FF on the next output update; after release the scan restarts at digit 0 with a cleared shadow.
- With LEADING_ZERO_BLANK_EN: data=32'h00000705, en_mask=FF -> only digits 0, 1, 2 are driven (5, 0, 7); digits 3-7 stay at AN bit 1.
